// File: rtl/std_seq_mem_d1.sv
// Single-port 1-D memory with a registered, multi-cycle read path and done/busy handshake.
// Out-of-bounds accesses are dropped (writes) or return zero (reads) and set a sticky error flag.
module std_seq_mem_d1 #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SIZE         = 16,
    parameter int unsigned IDX_SIZE     = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    write_data,
    input  logic                write_en,
    input  logic                read_en,
    output logic [WIDTH-1:0]    read_data,
    output logic                done,
    output logic                busy,
    output logic                error
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    logic [WIDTH-1:0]    mem [SIZE];

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_SIZE-1:0] addr_q;
    logic                oob_q;
    logic [WIDTH-1:0]    read_data_q;
    logic                done_q;
    logic                busy_q;
    logic                error_q;

    logic                addr_oob_c;
    logic                wr_acc_c;
    logic                rd_acc_c;
    logic [IDX_SIZE-1:0] rd_addr_c;
    logic                rd_oob_c;
    logic [WIDTH-1:0]    rd_word_c;

    // Request acceptance; a write wins over a simultaneous read.
    always_comb begin
        addr_oob_c = {1'b0, addr0} >= (IDX_SIZE+1)'(SIZE);
        wr_acc_c   = !reset && !busy_q && write_en;
        rd_acc_c   = !reset && !busy_q && read_en && !write_en;
        rd_addr_c  = (state_q == READ) ? addr_q : addr0;
        rd_oob_c   = (state_q == READ) ? oob_q  : addr_oob_c;
        rd_word_c  = rd_oob_c ? '0 : mem[rd_addr_c];
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c && !addr_oob_c) begin
            mem[addr0] <= write_data;
        end
    end

    // Control FSM: IDLE accepts requests, READ counts down the remaining latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            oob_q       <= 1'b0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_acc_c) begin
                        done_q <= 1'b1;
                        if (addr_oob_c) error_q <= 1'b1;
                    end else if (rd_acc_c) begin
                        if (addr_oob_c) error_q <= 1'b1;
                        if (READ_LATENCY <= 1) begin
                            read_data_q <= rd_word_c;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= READ;
                            cnt_q   <= CNT_W'(READ_LATENCY - 1);
                            addr_q  <= addr0;
                            oob_q   <= addr_oob_c;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == CNT_W'(1)) begin
                        read_data_q <= rd_word_c;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_data = read_data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign error     = error_q;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Directed bench for std_seq_mem_d1: three instances (RL=1/SIZE=12, RL=3, RL=4) share clk and reset.
module tb_std_seq_mem_d1;

    logic        clk;
    logic        reset;
    logic [3:0]  addr  [3];
    logic [31:0] wdata [3];
    logic        we    [3];
    logic        re    [3];
    logic [31:0] rdata [3];
    logic        done  [3];
    logic        busy  [3];
    logic        err   [3];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        std_seq_mem_d1 #(
            .WIDTH       (32),
            .SIZE        ((g == 0) ? 12 : 16),
            .IDX_SIZE    (4),
            .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .addr0     (addr[g]),
            .write_data(wdata[g]),
            .write_en  (we[g]),
            .read_en   (re[g]),
            .read_data (rdata[g]),
            .done      (done[g]),
            .busy      (busy[g]),
            .error     (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [3:0]  a;
        logic [31:0] d;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_o(input int k, input string tag, input logic e_done, input logic e_busy,
                         input logic [31:0] e_rd, input logic e_err);
        chk($sformatf("u%0d %s done", k, tag), 32'(done[k]), 32'(e_done));
        chk($sformatf("u%0d %s busy", k, tag), 32'(busy[k]), 32'(e_busy));
        chk($sformatf("u%0d %s rdata", k, tag), rdata[k], e_rd);
        chk($sformatf("u%0d %s error", k, tag), 32'(err[k]), 32'(e_err));
    endtask

    // Drive one cycle of inputs on instance k, advance to the next mid-cycle point, then idle it.
    task automatic cyc(input int k, input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
        we[k] = w; re[k] = r; addr[k] = a; wdata[k] = d;
        @(negedge clk);
        we[k] = 1'b0; re[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; re[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) chk_o(k, "por", 1'b0, 1'b0, 32'h0, 1'b0);

        // Seed a word, then hold reset with live requests: nothing may be accepted.
        cyc(0, 1'b1, 1'b0, 4'd5, 32'h0000_0055);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b1; re[k] = 1'b1; addr[k] = 4'd5; wdata[k] = 32'h0000_0BAD;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk_o(k, $sformatf("rst%0d", c), 1'b0, 1'b0, 32'h0, 1'b0);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; re[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        @(negedge clk);
        chk_o(0, "rst_idle", 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(0, 1'b0, 1'b1, 4'd5, 32'h0);
        chk_o(0, "rst_nowr", 1'b1, 1'b0, 32'h0000_0055, 1'b0);

        // RL=1, SIZE=12 vector table
        vt[0]  = '{1'b1, 1'b0, 4'd3,  32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0055, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 4'd3,  32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 4'd7,  32'h0000_00A5, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 4'd7,  32'h0,         1'b1, 1'b0, 32'h0000_00A5, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 4'd3,  32'h1111_1111, 1'b1, 1'b0, 32'h0000_00A5, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 4'd11, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_00A5, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 4'd11, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 4'd3,  32'h0,         1'b1, 1'b0, 32'h1111_1111, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 4'd13, 32'h0000_00FF, 1'b1, 1'b0, 32'h1111_1111, 1'b1};
        vt[10] = '{1'b0, 1'b1, 4'd13, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
        vt[11] = '{1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
        vt[12] = '{1'b1, 1'b0, 4'd12, 32'h0000_0077, 1'b1, 1'b0, 32'h0,         1'b1};
        vt[13] = '{1'b0, 1'b1, 4'd12, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1};
        vt[14] = '{1'b0, 1'b1, 4'd7,  32'h0,         1'b1, 1'b0, 32'h0000_00A5, 1'b1};
        vt[15] = '{1'b0, 1'b1, 4'd11, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D, 1'b1};
        for (int i = 0; i < 16; i++) begin
            cyc(0, vt[i].w, vt[i].r, vt[i].a, vt[i].d);
            chk_o(0, $sformatf("v%0d", i), vt[i].e_done, vt[i].e_busy, vt[i].e_rd, vt[i].e_err);
        end

        // RL=3: a write arriving while busy must be ignored
        cyc(1, 1'b1, 1'b0, 4'd5, 32'h0000_1234);
        chk_o(1, "wr5", 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1, 1'b0, 1'b1, 4'd5, 32'h0);
        chk_o(1, "rl3_c1", 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1, 1'b1, 1'b0, 4'd5, 32'h0000_9999);
        chk_o(1, "rl3_c2", 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1, 1'b0, 1'b0, 4'd0, 32'h0);
        chk_o(1, "rl3_c3", 1'b1, 1'b0, 32'h0000_1234, 1'b0);
        cyc(1, 1'b0, 1'b1, 4'd5, 32'h0);
        chk_o(1, "rl3_r2c1", 1'b0, 1'b1, 32'h0000_1234, 1'b0);
        cyc(1, 1'b0, 1'b0, 4'd0, 32'h0);
        chk_o(1, "rl3_r2c2", 1'b0, 1'b1, 32'h0000_1234, 1'b0);
        cyc(1, 1'b0, 1'b0, 4'd0, 32'h0);
        chk_o(1, "rl3_r2c3", 1'b1, 1'b0, 32'h0000_1234, 1'b0);

        // RL=4: full read, then a read aborted by reset, then a fresh read
        cyc(2, 1'b1, 1'b0, 4'd9, 32'h0000_ABCD);
        chk_o(2, "wr9", 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2, 1'b0, 1'b1, 4'd9, 32'h0);
        for (int c = 1; c < 4; c++) begin
            chk_o(2, $sformatf("rl4_c%0d", c), 1'b0, 1'b1, 32'h0, 1'b0);
            cyc(2, 1'b0, 1'b0, 4'd0, 32'h0);
        end
        chk_o(2, "rl4_c4", 1'b1, 1'b0, 32'h0000_ABCD, 1'b0);
        cyc(2, 1'b0, 1'b1, 4'd9, 32'h0);
        chk_o(2, "ab_c1", 1'b0, 1'b1, 32'h0000_ABCD, 1'b0);
        cyc(2, 1'b0, 1'b0, 4'd0, 32'h0);
        chk_o(2, "ab_c2", 1'b0, 1'b1, 32'h0000_ABCD, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_o(2, "ab_c3", 1'b0, 1'b0, 32'h0, 1'b0);
        chk(("u0 err_cleared"), 32'(err[0]), 32'h0);
        cyc(2, 1'b0, 1'b1, 4'd9, 32'h0);
        for (int c = 4; c < 7; c++) begin
            chk_o(2, $sformatf("ab_c%0d", c), 1'b0, 1'b1, 32'h0, 1'b0);
            cyc(2, 1'b0, 1'b0, 4'd0, 32'h0);
        end
        chk_o(2, "ab_c7", 1'b1, 1'b0, 32'h0000_ABCD, 1'b0);
        @(negedge clk);
        chk_o(2, "ab_c8", 1'b0, 1'b0, 32'h0000_ABCD, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/std_seq_mem_d1.md
# std_seq_mem_d1

Single-port, one-dimensional memory with a registered, multi-cycle read path and go/done-style handshakes. It is the sequential-read counterpart of the combinational-read 1-D memory primitive. The compiler's memory lowering targets it where block-RAM inference or a deeper read pipeline is required. Out-of-bounds accesses are reported through a sticky error flag rather than only a simulation message.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1)
- SIZE, 16, number of words (≥1, ≤ 2^IDX_SIZE)
- IDX_SIZE, 4, address width in bits
- READ_LATENCY, 1, cycles from read acceptance to data valid (1..4)

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- addr0  input  IDX_SIZE  word address, sampled when a request is accepted
- write_data  input  WIDTH  data to store, sampled with write_en
- write_en  input  1  write request
- read_en  input  1  read request
- read_data  output  WIDTH  registered read result, held until the next read completes
- done  output  1  one-cycle pulse marking completion of an accepted read or write
- busy  output  1  high while a read is in flight and new requests are ignored
- error  output  1  sticky flag set by any accepted out-of-bounds access

## Operation
- The block has one clock and a synchronous, active-high reset.
- States:
  - IDLE: no request in flight.
  - READ: counting down the read latency.
- Acceptance: a request is accepted on a rising edge where busy=0.
  - While busy=1, write_en and read_en are ignored. No write occurs and no done pulse is produced.
- Write (write_en=1 when accepted):
  - mem[addr0] ← write_data at that edge.
  - done=1 for the following cycle.
  - State stays IDLE.
- Simultaneous write_en and read_en: the write wins. The read is dropped with no second done pulse.
- Read (read_en=1, write_en=0 when accepted):
  - addr0 is captured.
  - If READ_LATENCY=1, the result is loaded directly into read_data and done pulses next cycle.
  - Otherwise the state goes to READ with a counter of READ_LATENCY-1. busy=1 until the final edge, then read_data is loaded, done pulses, and the state returns to IDLE.
- Out of bounds (addr0 ≥ SIZE at acceptance):
  - A write does not modify memory.
  - A read returns all-zero read_data.
  - done still pulses at the normal time.
  - error goes high the cycle after acceptance and stays high until reset.
- read_data changes only on read completion or reset. Writes never alter read_data, even to the last-read address.
- Reset:
  - Output values: read_data=0, done=0, busy=0, error=0. State returns to IDLE and the counter clears.
  - Memory contents are not cleared.
  - Reset during READ aborts the read: no done pulse, and read_data is 0.
  - Reset has priority over any request in the same cycle; that request is not accepted.

## Timing
- Write latency is 1: request in cycle n, done in cycle n+1. The written data is readable by a read accepted in cycle n+1.
- Read latency:
  - Request in cycle n; read_data valid and done=1 in cycle n+READ_LATENCY.
  - busy=1 in cycles n+1 .. n+READ_LATENCY-1, and 0 in the done cycle.
- Throughput:
  - A new request may be accepted in the done cycle.
  - Reads sustain one per READ_LATENCY cycles; writes sustain one per cycle.
- done is never high for two consecutive cycles from the same request. Back-to-back accepted writes give consecutive done pulses, one per write.
- Read-after-write to the same address in consecutive cycles returns the new data.

## Test plan
- Reset then idle:
  - Stimulus: assert reset 2 cycles with write_en=1, read_en=1.
  - Required: read_data=0, done=0, busy=0, error=0 throughout and after; no memory write occurred.
- Write/read, READ_LATENCY=1, WIDTH=32, SIZE=16:
  - Stimulus: write 0xDEADBEEF to addr 3 in cycle 0; read addr 3 in cycle 1.
  - Required: done in cycles 1 and 2; read_data=0xDEADBEEF in cycle 2.
- READ_LATENCY=3:
  - Stimulus: read addr 5 (holding 0x1234) in cycle 0; a write request to addr 5 in cycle 1.
  - Required: busy=1 in cycles 1–2; the write is ignored; done=1 and read_data=0x1234 in cycle 3; a later read of addr 5 still returns 0x1234.
- Simultaneous requests:
  - Stimulus: write_en=1, read_en=1, addr 7, data 0xA5 in cycle 0.
  - Required: mem[7]=0xA5; exactly one done, in cycle 1; read_data unchanged.
- Out of bounds, SIZE=12, IDX_SIZE=4:
  - Stimulus: write 0xFF to addr 13, then read addr 13.
  - Required: no memory change; read returns 0; done pulses for both; error=1 from the cycle after the write and held until reset.
- Reset mid-read, READ_LATENCY=4:
  - Stimulus: read accepted in cycle 0; reset asserted in cycle 2.
  - Required: no done pulse; busy=0 and read_data=0 from cycle 3; a new read accepted in cycle 3 completes in cycle 7.
